// File: rtl/thirty_two_bit_serial_addsub.sv
// thirty_two_bit_serial_addsub: nibble-serial WIDTH-bit adder/subtractor fed by a slice-wise NOT stage
// Ports: clk, rst (sync, active-high); start/sub/a/b request sampled in IDLE;
//        busy (RUN), done (one-cycle pulse), result, carry, overflow, zero.
// Optional macro SERIAL_ADDSUB_SAT_EN: saturate result on signed overflow.

module thirty_two_bit_not #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);
    for (genvar i = 0; i < WIDTH / SLICE; i++) begin : g_slice
        assign y[i*SLICE +: SLICE] = ~a[i*SLICE +: SLICE];
    end
endmodule

module thirty_two_bit_serial_addsub #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW = $clog2(NSLICE);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] a_r, b_r, b_n, res_n, fin;
    logic [IW-1:0] idx;
    logic cin, last, ovf;
    logic [SLICE:0] sum;
    thirty_two_bit_not #(.WIDTH(WIDTH), .SLICE(SLICE)) u_not (.a(b), .y(b_n));
    assign busy = state == RUN;
    assign done = state == DONE;
    assign last = idx == IW'(NSLICE - 1);
    assign sum = {1'b0, a_r[idx*SLICE +: SLICE]} + {1'b0, b_r[idx*SLICE +: SLICE]} + (SLICE + 1)'(cin);
    always_comb begin
        res_n = result;
        res_n[idx*SLICE +: SLICE] = sum[SLICE-1:0];
    end
    // Flags are taken from the fully assembled word, including the slice written on the last edge.
    assign ovf = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (res_n[WIDTH-1] != a_r[WIDTH-1]);
`ifdef SERIAL_ADDSUB_SAT_EN
    assign fin = ovf ? {a_r[WIDTH-1], {(WIDTH-1){~a_r[WIDTH-1]}}} : res_n;
`else
    assign fin = res_n;
`endif
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = start ? RUN : IDLE;
            RUN:  state_n = last ? DONE : RUN;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= '0;
            b_r <= '0;
            cin <= 1'b0;
            idx <= '0;
            result <= '0;
            carry <= 1'b0;
            overflow <= 1'b0;
            zero <= 1'b0;
        end else if (state == IDLE && start) begin
            a_r <= a;
            b_r <= sub ? b_n : b;
            cin <= sub;
            idx <= '0;
            result <= '0;
            carry <= 1'b0;
            overflow <= 1'b0;
            zero <= 1'b0;
        end else if (state == RUN) begin
            cin <= sum[SLICE];
            idx <= idx + 1'b1;
            result <= last ? fin : res_n;
            if (last) begin
                carry <= sum[SLICE];
                overflow <= ovf;
                zero <= fin == '0;
            end
        end
    end
endmodule

// File: tb/tb_thirty_two_bit_serial_addsub.sv
// tb_thirty_two_bit_serial_addsub: directed self-checking bench for the serial adder/subtractor
module tb_thirty_two_bit_serial_addsub;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, sub = 1'b0;
    logic [31:0] a = '0, b = '0, result;
    logic busy, done, carry, overflow, zero;
    int n_chk = 0, n_pass = 0;

    thirty_two_bit_serial_addsub dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .carry(carry), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic op(input logic s, input logic [31:0] x, input logic [31:0] y, input int p1, input int p2,
                      input logic [31:0] er, input logic ec, input logic eo, input logic ez);
        int cyc;
        logic busy_ok;
        @(posedge clk); #1;
        start = 1'b1; sub = s; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; sub = ~s; a = ~x; b = ~y;
        cyc = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 20) begin
            if (!busy) busy_ok = 1'b0;
            start = (cyc == p1);
            if (start) begin a = 32'd100; b = 32'd100; end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'd9);
        chk("busy_run", {31'b0, busy_ok}, 32'd1);
        chk("busy_done", {31'b0, busy}, 32'd0);
        chk("result", result, er);
        chk("carry", {31'b0, carry}, {31'b0, ec});
        chk("overflow", {31'b0, overflow}, {31'b0, eo});
        chk("zero", {31'b0, zero}, {31'b0, ez});
        start = (cyc == p2);
        a = 32'd100; b = 32'd100;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_pulse", {31'b0, done}, 32'd0);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("result_hold", result, er);
    endtask

    initial begin
        logic seen;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_carry", {31'b0, carry}, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd0);

        op(1'b0, 32'd5, 32'd7, -1, -1, 32'h0000000C, 1'b0, 1'b0, 1'b0);
        op(1'b1, 32'd5, 32'd7, -1, -1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        op(1'b1, 32'd7, 32'd5, -1, -1, 32'h00000002, 1'b1, 1'b0, 1'b0);
        op(1'b0, 32'hFFFFFFFF, 32'd1, -1, -1, 32'h00000000, 1'b1, 1'b0, 1'b1);
`ifdef SERIAL_ADDSUB_SAT_EN
        op(1'b0, 32'h7FFFFFFF, 32'd1, -1, -1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
`else
        op(1'b0, 32'h7FFFFFFF, 32'd1, -1, -1, 32'h80000000, 1'b0, 1'b1, 1'b0);
`endif
        op(1'b0, 32'd1, 32'd2, 3, 9, 32'h00000003, 1'b0, 1'b0, 1'b0);

        @(posedge clk); #1;
        start = 1'b1; sub = 1'b0; a = 32'h12345678; b = 32'h11111111;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_result", result, 32'h0);
        chk("abort_done", {31'b0, done}, 32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        chk("abort_quiet", {31'b0, seen}, 32'd0);
        op(1'b0, 32'h12345678, 32'h11111111, -1, -1, 32'h23456789, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
